// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised multi-cycle accumulator CPU (SAP-1 family).
// Internal RAM is loaded through the programming port while clr is low.
// Each instruction walks T1..T5 (fetch, decode/execute, memory, ALU);
// HLT parks the machine in HALT until the next clr.
module sap_cpu_param #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Architectural state
  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              c_flag;
  logic              z_flag;
  logic [DATA_W-1:0] ram [0:DEPTH-1];

  // Next-state values produced by the decode process
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] mar_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic              c_nxt;
  logic              z_nxt;
  logic [DATA_W-1:0] out_nxt;
  logic              out_valid_nxt;
  logic              ram_we;

  // Decoded fields and datapath helpers
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W:0]   alu;

  assign opcode      = ir[DATA_W-1 -: 4];
  assign operand     = ir[ADDR_W-1:0];
  assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, operand};
  assign pc_ext      = {{(DATA_W-ADDR_W){1'b0}}, pc};
  assign ram_rd      = ram[mar];

  // ALU: add, or subtract as A + ~B + 1 so carry-out means "no borrow"
  always_comb begin
    alu = {(DATA_W+1){1'b0}};
    if (opcode == OP_SUB) begin
      alu = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      alu = {1'b0, a} + {1'b0, b};
    end
  end

  // Sequencer: next-state, register updates and bus contents per T-state
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    mar_nxt       = mar;
    ir_nxt        = ir;
    a_nxt         = a;
    b_nxt         = b;
    c_nxt         = c_flag;
    z_nxt         = z_flag;
    out_nxt       = out;
    out_valid_nxt = 1'b0;
    ram_we        = 1'b0;
    bus           = {DATA_W{1'b0}};
    case (state)
      T1: begin
        mar_nxt   = pc;
        bus       = pc_ext;
        state_nxt = T2;
      end
      T2: begin
        ir_nxt    = ram_rd;
        pc_nxt    = pc + ADDR_W'(1);
        bus       = ram_rd;
        state_nxt = T3;
      end
      T3: begin
        state_nxt = T1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_nxt   = operand;
            bus       = operand_ext;
            state_nxt = T4;
          end
          OP_LDI: begin
            a_nxt = operand_ext;
            z_nxt = (operand_ext == {DATA_W{1'b0}});
            bus   = operand_ext;
          end
          OP_JMP: begin
            pc_nxt = operand;
            bus    = operand_ext;
          end
          OP_JC: begin
            if (c_flag) begin
              pc_nxt = operand;
            end else begin
              pc_nxt = pc;
            end
            bus = operand_ext;
          end
          OP_JZ: begin
            if (z_flag) begin
              pc_nxt = operand;
            end else begin
              pc_nxt = pc;
            end
            bus = operand_ext;
          end
          OP_OUT: begin
            out_nxt       = a;
            out_valid_nxt = 1'b1;
            bus           = a;
          end
          OP_HLT: begin
            state_nxt = HALT;
          end
          default: begin
            state_nxt = T1;
          end
        endcase
      end
      T4: begin
        state_nxt = T1;
        case (opcode)
          OP_LDA: begin
            a_nxt = ram_rd;
            z_nxt = (ram_rd == {DATA_W{1'b0}});
            bus   = ram_rd;
          end
          OP_ADD, OP_SUB: begin
            b_nxt     = ram_rd;
            bus       = ram_rd;
            state_nxt = T5;
          end
          OP_STA: begin
            ram_we = 1'b1;
            bus    = a;
          end
          default: begin
            state_nxt = T1;
          end
        endcase
      end
      T5: begin
        a_nxt     = alu[DATA_W-1:0];
        c_nxt     = alu[DATA_W];
        z_nxt     = (alu[DATA_W-1:0] == {DATA_W{1'b0}});
        bus       = alu[DATA_W-1:0];
        state_nxt = T1;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = T1;
      end
    endcase
  end

  // State register with synchronous active-low clear of all CPU registers
  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= T1;
      pc        <= {ADDR_W{1'b0}};
      mar       <= {ADDR_W{1'b0}};
      ir        <= {DATA_W{1'b0}};
      a         <= {DATA_W{1'b0}};
      b         <= {DATA_W{1'b0}};
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out       <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      mar       <= mar_nxt;
      ir        <= ir_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      c_flag    <= c_nxt;
      z_flag    <= z_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      halted    <= (state_nxt == HALT);
    end
  end

  // RAM write port: programming while in reset, STA while running
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (prog_we) begin
        ram[prog_addr] <= prog_data;
      end
    end else if (ram_we) begin
      ram[mar] <= a;
    end
  end

endmodule

// File: tb/tb_sap_cpu_param.sv
// Testbench for sap_cpu_param: table-driven programs on the 4/8 instance,
// plus hand-written reset and PC-wrap sequences (the latter on a 5/12 instance).
module tb_sap_cpu_param;

  logic       clk = 1'b0;
  logic       clr;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] bus;
  logic [7:0] out;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc;

  logic        clr2;
  logic        prog_we2;
  logic [4:0]  prog_addr2;
  logic [11:0] prog_data2;
  logic [11:0] bus2;
  logic [11:0] out2;
  logic        out_valid2;
  logic        halted2;
  logic [4:0]  pc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sap_cpu_param #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .clr(clr), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .bus(bus), .out(out), .out_valid(out_valid),
    .halted(halted), .pc(pc)
  );

  sap_cpu_param #(.ADDR_W(5), .DATA_W(12)) dut2 (
    .clk(clk), .clr(clr2), .prog_we(prog_we2), .prog_addr(prog_addr2),
    .prog_data(prog_data2), .bus(bus2), .out(out2), .out_valid(out_valid2),
    .halted(halted2), .pc(pc2)
  );

  typedef struct packed {
    logic [127:0] prog;      // word i at bits [8i+7:8i]
    logic [2:0]   n_outs;
    logic [31:0]  outs;      // first expected out in the low byte
    logic [7:0]   exp_a;
    logic         exp_c;
    logic         exp_z;
    logic [7:0]   halt_cyc;  // edges from release to halted
    logic [3:0]   chk_addr;
    logic [7:0]   chk_val;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [127:0] p);
    clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = p[8*i +: 8];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_to_halt(input vec_t v, input string tag);
    int edges;
    int n_seen;
    edges  = 0;
    n_seen = 0;
    clr    = 1'b1;
    while (!halted && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid) begin
        if (n_seen < int'(v.n_outs)) begin
          check({tag, " out"}, {24'h0, out}, {24'h0, v.outs[8*n_seen +: 8]});
        end
        n_seen++;
      end
    end
    check({tag, " halted"}, {31'h0, halted}, 32'h1);
    check({tag, " halt_cycles"}, edges, {24'h0, v.halt_cyc});
    check({tag, " n_out_pulses"}, n_seen, {29'h0, v.n_outs});
    check({tag, " A"}, {24'h0, dut.a}, {24'h0, v.exp_a});
    check({tag, " C"}, {31'h0, dut.c_flag}, {31'h0, v.exp_c});
    check({tag, " Z"}, {31'h0, dut.z_flag}, {31'h0, v.exp_z});
    check({tag, " ram"}, {24'h0, dut.ram[v.chk_addr]}, {24'h0, v.chk_val});
    check({tag, " bus_halt"}, {24'h0, bus}, 32'h0);
  endtask

  initial begin
    vec_t v5;
    logic [127:0] p5;

    clr = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    clr2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = 5'h0; prog_data2 = 12'h000;

    // prog, n_outs, outs, A, C, Z, halt cycles, ram addr, ram value
    vecs[0] = '{128'h00000000_060E1C00_000000F0_E03B2A19, 3'd1, 32'h00000024,
                8'h24, 1'b1, 1'b0, 8'd20, 4'h9, 8'h1C};
    vecs[1] = '{128'h01000000_00000000_00F0E061_853FE053, 3'd4, 32'h00010203,
                8'h00, 1'b1, 1'b1, 8'd48, 4'hF, 8'h01};
    vecs[2] = '{128'hFF010000_00000000_0000F0E0_F0742F1E, 3'd1, 32'h00000000,
                8'h00, 1'b1, 1'b1, 8'd18, 4'hE, 8'h01};
    vecs[3] = '{128'h00000000_00000000_0000F0E0_1E504E57, 3'd1, 32'h00000007,
                8'h07, 1'b0, 1'b0, 8'd20, 4'hE, 8'h07};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst pc", {28'h0, pc}, 32'h0);
    check("rst out", {24'h0, out}, 32'h0);
    check("rst out_valid", {31'h0, out_valid}, 32'h0);
    check("rst halted", {31'h0, halted}, 32'h0);

    // Table-driven programs
    for (int t = 0; t < 4; t++) begin
      load_prog(vecs[t].prog);
      run_to_halt(vecs[t], $sformatf("prog%0d", t + 1));
    end

    // Reset during T4 of STA aborts the store
    p5 = vecs[3].prog;
    p5[8*14 +: 8] = 8'h33;
    load_prog(p5);
    clr = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sta_t4 bus", {24'h0, bus}, 32'h07);
    clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort ram", {24'h0, dut.ram[14]}, 32'h33);
    check("abort pc", {28'h0, pc}, 32'h0);
    check("abort A", {24'h0, dut.a}, 32'h0);
    check("abort mar", {28'h0, dut.mar}, 32'h0);
    check("abort ir", {24'h0, dut.ir}, 32'h0);
    check("abort out", {24'h0, out}, 32'h0);
    check("abort halted", {31'h0, halted}, 32'h0);
    check("abort bus", {24'h0, bus}, 32'h0);
    // prog_we while running must be ignored
    clr       = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'hF;
    prog_data = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
    check("prog_we_ignored", {24'h0, dut.ram[15]}, 32'h0);
    v5 = vecs[3];
    v5.halt_cyc = 8'd19;
    run_to_halt(v5, "restart");

    // Wide instance: NOP sweep, PC wraps 31 -> 0, bus shows PC at T1
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      prog_we2   = 1'b1;
      prog_addr2 = 5'(i);
      prog_data2 = 12'h000;
    end
    @(negedge clk);
    prog_we2 = 1'b0;
    clr2     = 1'b1;
    for (int k = 0; k <= 99; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (k % 3 == 0) begin
        check("wide pc", {27'h0, pc2}, 32'((k / 3) % 32));
        check("wide bus", {20'h0, bus2}, 32'((k / 3) % 32));
      end
    end
    check("wide halted", {31'h0, halted2}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sap_cpu_param.md
Name: sap_cpu_param

Overview:
Parametrised successor to the fixed 8-bit SAP-1 top level. It is a multi-cycle accumulator CPU with internal RAM, an output register and an observable internal bus.
- Generalised in data and address width.
- Adds STA, LDI, JMP, JC, JZ and carry/zero flags.
- Adds a programming port for loading RAM while in reset.
- Benches drive only clk and clr, preload RAM through the programming port, and watch out/bus.

Parameters:
- ADDR_W, 4, address width; RAM depth 2^ADDR_W; operand field width.
- DATA_W, 8, word width of RAM, A, B and out. DATA_W >= ADDR_W+4 is required. Opcode is bits [DATA_W-1:DATA_W-4]; operand is bits [ADDR_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous active-low reset.
- prog_we  in  1  RAM write strobe; honoured only while clr==0.
- prog_addr  in  ADDR_W  programming address.
- prog_data  in  DATA_W  programming data.
- bus  out  DATA_W  value transferred in the current T-state; 0 when idle or halted.
- out  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out is loaded.
- halted  out  1  high in HALT state.
- pc  out  ADDR_W  program counter, for debug.

Behaviour:
Reset (clr==0 at posedge):
- PC, MAR, IR, A, B, out, C and Z are set to 0; out_valid=0; halted=0; state=T1.
- RAM is not cleared. If prog_we=1, RAM[prog_addr]<=prog_data.
- Reset aborts any instruction in flight; no pending RAM write, flag update or out load completes.
- prog_we is ignored when clr==1.

States: T1, T2, T3, T4, T5, HALT. One state per clock.
- T1: MAR<=PC; bus=PC zero-extended.
- T2: IR<=RAM[MAR]; PC<=PC+1 mod 2^ADDR_W; bus=RAM[MAR].
- T3: decode and execute on IR opcode.
  - 0 NOP: -> T1.
  - 1 LDA, 2 ADD, 3 SUB, 4 STA: MAR<=operand -> T4.
  - 5 LDI: A<=zero-extended operand; Z updated; -> T1.
  - 6 JMP: PC<=operand.
  - 7 JC: PC<=operand if C=1.
  - 8 JZ: PC<=operand if Z=1.
  - 6, 7, 8 all -> T1; not-taken still takes 3 cycles.
  - E OUT: out<=A; out_valid=1 on the following cycle only; -> T1.
  - F HLT: -> HALT.
  - All other opcodes behave as NOP.
- T4:
  - LDA: A<=RAM[MAR]; Z updated; C unchanged; -> T1.
  - ADD/SUB: B<=RAM[MAR]; -> T5.
  - STA: RAM[MAR]<=A; -> T1.
- T5:
  - ADD: {C,A}<=A+B.
  - SUB: {C,A}<=A+~B+1, so C=1 means no borrow.
  - Z<=(result==0) for both; -> T1.
- HALT: all registers hold; halted=1; bus=0. Left only via clr.

Cycle counts:
- 3 cycles: NOP, LDI, JMP, JC, JZ, OUT, HLT (HLT reaches HALT on its 3rd edge).
- 4 cycles: LDA, STA.
- 5 cycles: ADD, SUB.

Edge rules:
- PC wraps from 2^ADDR_W-1 to 0.
- Flags are written only by LDA, LDI, ADD and SUB.
- A jump uses the flags as they stood at T3.
- A self-modifying STA is visible to the next fetch.

Test Plan:
1. Program with ADDR_W=4, DATA_W=8: 0:19, 1:2A, 2:3B, 3:E0, 4:F0; data 9:1C, A:0E, B:06. Release clr.
   -> out=24h with a single out_valid pulse; halted rises 20 cycles after release; C=1, Z=0.
2. Countdown loop: 0:53, 1:E0, 2:3F, 3:85, 4:61, 5:E0, 6:F0; F:01.
   -> out_valid pulses carry 03, 02, 01, 00 in order, then halted.
3. Carry and zero: 0:1E, 1:2F, 2:74, 3:F0, 4:E0, 5:F0; E:01, F:FF.
   -> A=00, C=1, Z=1; JC taken; out=00; halted.
4. Store/load: 0:57, 1:4E, 2:50, 3:1E, 4:E0, 5:F0.
   -> RAM[E]=07; out=07.
5. Reset behaviour:
   - Assert clr low during T4 of an STA -> RAM unchanged; all registers 0; restart from addr 0.
   - prog_we pulsed while clr=1 -> RAM unchanged.
6. ADDR_W=5, DATA_W=12: NOPs filling 0..31 with clr released.
   -> pc counts 0..31 then wraps to 0; bus shows PC at each T1.
